lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control unit directly upstream of the data memory.
- Takes one load/store request per transaction from the execute stage and computes the effective address.
- Checks alignment and drives a word-wide, byte-enabled memory port with a request/grant/rvalid handshake.
- Returns the aligned, sign- or zero-extended load result, or a completion/error status, to writeback. Funct3 encodings match the data-memory load/store codes.

Parameters:
- TIMEOUT, 16, cycles to wait for mem_rvalid after grant before flagging a bus error; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  execute stage presents a request
- req_ready  output  1  LSU accepts a request (IDLE only)
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
- req_base  input  32  rs1 value
- req_offset  input  32  sign-extended immediate
- req_wdata  input  32  rs2 value (stores)
- req_rd  input  5  destination register (loads)
- mem_req  output  1  memory access request
- mem_gnt  input  1  memory accepts the request this cycle
- mem_we  output  1  write strobe, qualified by mem_req
- mem_addr  output  32  word-aligned address, {ea[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_rvalid  input  1  read data valid; arrives at least 1 cycle after the load grant
- mem_rdata  input  32  read word
- resp_valid  output  1  response available
- resp_ready  input  1  writeback consumes the response
- resp_data  output  32  extended load result; 0 for stores and errors
- resp_rd  output  5  latched req_rd; 0 for stores
- resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- resp_addr  output  32  effective address of the transaction

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; all outputs 0 except req_ready=1. The timeout counter and all latches are cleared.
- Reset mid-transaction aborts the access immediately: mem_req drops the next cycle, and a stale mem_rvalid arriving afterwards in IDLE is ignored.
- Effective address: ea = req_base + req_offset, modulo 2^32, no overflow flag.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid: latch ea, funct3, we, wdata, rd.
  - Illegal funct3 (load 011/110/111; store other than 000/001/010): go to RESP with err=10.
  - Else misaligned (halfword with ea[0]=1; word with ea[1:0]!=0): go to RESP with err=01, no memory access.
  - Else go to ACCESS.
- ACCESS
  - mem_req=1; address, be, we and wdata are held stable until mem_gnt.
  - On gnt: a store goes to RESP with err=00; a load clears the counter and goes to WAIT.
  - No timeout applies while waiting for grant.
- WAIT
  - mem_req=0. The counter increments each cycle.
  - On mem_rvalid: capture and extend the data, go to RESP with err=00.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without rvalid: go to RESP with err=11, resp_data=0.
  - rvalid on the same cycle the counter expires counts as success.
- RESP
  - resp_valid=1; all resp_* fields are held stable until resp_ready.
  - On resp_ready: go to IDLE.
  - req_ready=0 outside IDLE, so there is no overlap. Minimum throughput: store 3 cycles, load 4 cycles.
- Store lanes:
  - SB: be=0001<<ea[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=0011 (ea[1]=0) or 1100, wdata={2{wdata[15:0]}}.
  - SW: be=1111, wdata unchanged.
- Load extract: sh = 8*ea[1:0].
  - LB/LBU take rdata[sh+7:sh], sign- or zero-extended.
  - LH/LHU take rdata[ea[1]*16+15 : ea[1]*16], sign- or zero-extended.
  - LW takes the full word.
- mem_we=0 and mem_be=0 whenever mem_req=0.

Test Plan:
- Reset then SW: base=0x100, off=0x4, wdata=0xDEADBEEF, gnt on 1st cycle -> mem_addr=0x104, be=1111, wdata=0xDEADBEEF; resp_valid 2 cycles after accept, err=00.
- LB sign extension: ea=0x203, rdata=0x80112233 -> resp_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH at ea=0x102, rdata=0x9ABC1234 -> resp_data=0xFFFF9ABC. SH of wdata=0x00005678 to ea=0x102 -> be=1100, mem_wdata=0x56785678.
- Misaligned LW at ea=0x101 -> no mem_req; resp_err=01, resp_addr=0x101, resp_data=0. Illegal load funct3=011 -> resp_err=10.
- Grant stall: mem_gnt held low 5 cycles -> mem_req/addr/be stable throughout. TIMEOUT=4 with no rvalid -> resp_err=11 after exactly 4 WAIT cycles.
- Backpressure/reset: resp_ready low 3 cycles -> resp fields stable, req_ready=0. rst_n=0 during WAIT -> IDLE next cycle; a later mem_rvalid produces no resp_valid.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-side request, data-memory port and writeback response
// signals that connect to the load/store unit.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic [31:0] resp_addr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output resp_valid, resp_data, resp_rd, resp_err, resp_addr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  resp_valid, resp_data, resp_rd, resp_err, resp_addr
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control unit: effective address, alignment check, byte-enabled
// memory handshake with optional read timeout, and extended writeback result.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_ea, r_wdata, r_resp_data;
  logic [2:0]    r_funct3;
  logic          r_we;
  logic [4:0]    r_rd;
  logic [1:0]    r_err;
  logic [CW-1:0] r_cnt;

  logic [31:0] w_ea, w_ld_data, w_st_data;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_illegal, w_misaligned, w_expire;
  logic        w_req_ready, w_mem_req, w_resp_valid;

  assign w_ea = bus.req_base + bus.req_offset;

  always_comb begin
    w_illegal = 1'b1;
    if (bus.req_we)
      w_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      w_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  assign w_misaligned = (bus.req_funct3[1:0] == 2'b01 && w_ea[0]) ||
                        (bus.req_funct3[1:0] == 2'b10 && w_ea[1:0] != 2'b00);
  assign w_expire = (TIMEOUT != 0) && (r_cnt == LAST_CNT);

  // Store lane steering and load extraction, both keyed by the latched funct3/ea.
  always_comb begin
    w_be      = 4'b1111;
    w_st_data = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be      = 4'b0001 << r_ea[1:0];
        w_st_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = r_ea[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_ea[1:0])
      2'b01:   w_byte = bus.mem_rdata[15:8];
      2'b10:   w_byte = bus.mem_rdata[23:16];
      2'b11:   w_byte = bus.mem_rdata[31:24];
      default: ;
    endcase
    w_half = r_ea[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_mem_req    = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid)
          w_state_next = (w_illegal || w_misaligned) ? RESP : ACCESS;
      end
      ACCESS: begin
        w_mem_req = 1'b1;
        if (bus.mem_gnt)
          w_state_next = r_we ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid || w_expire)
          w_state_next = RESP;
      end
      RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ea        <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_funct3    <= '0;
      r_we        <= 1'b0;
      r_rd        <= '0;
      r_err       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_ea        <= w_ea;
          r_funct3    <= bus.req_funct3;
          r_we        <= bus.req_we;
          r_wdata     <= bus.req_wdata;
          r_rd        <= bus.req_rd;
          r_resp_data <= '0;
          r_err       <= w_illegal ? 2'b10 : (w_misaligned ? 2'b01 : 2'b00);
        end
        ACCESS: if (bus.mem_gnt) r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // rvalid wins over an expiring counter in the same cycle
          if (bus.mem_rvalid)   r_resp_data <= w_ld_data;
          else if (w_expire)    r_err       <= 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_req & r_we;
  assign bus.mem_addr   = w_mem_req ? {r_ea[31:2], 2'b00} : 32'd0;
  assign bus.mem_be     = w_mem_req ? w_be : 4'b0000;
  assign bus.mem_wdata  = (w_mem_req && r_we) ? w_st_data : 32'd0;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = w_resp_valid ? r_resp_data : 32'd0;
  assign bus.resp_rd    = (w_resp_valid && !r_we) ? r_rd : 5'd0;
  assign bus.resp_err   = w_resp_valid ? r_err : 2'b00;
  assign bus.resp_addr  = w_resp_valid ? r_ea : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed plus randomized bench for lsu_ctrl against a byte-level reference model.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  lsu_ctrl_if bus();

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected outcome from access size, byte offset and extension rules.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] ea,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int rdel,
                       output logic [1:0] err, output logic [31:0] data,
                       output logic [3:0] be, output logic [31:0] mwd);
    int size, off;
    bit legal;
    logic [31:0] v, mask;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << (int'(f3) % 4);
    off   = int'(ea % 4);
    data  = 32'd0;
    be    = 4'((1 << size) - 1) << off;
    mwd   = (size == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
            (size == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
    if (!legal)                        err = 2'b10;
    else if ((int'(ea) % size) != 0)   err = 2'b01;
    else if (we)                       err = 2'b00;
    else if (rdel >= TO)               err = 2'b11;
    else begin
      err  = 2'b00;
      mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 1);
      v    = (rdata >> (8 * off)) & mask;
      if (f3 < 3'd4 && size < 4 && v >= (32'd1 << (8 * size - 1)))
        v = v - (32'd1 << (8 * size));
      data = v;
    end
  endtask

  task automatic txn(input string tag, input bit we, input logic [2:0] f3,
                     input logic [31:0] base, input logic [31:0] off,
                     input logic [31:0] wdata, input logic [4:0] rd,
                     input logic [31:0] rdata, input int gdel, input int rdel, input int rdly);
    logic [31:0] ea, edata, emwd;
    logic [1:0]  eerr;
    logic [3:0]  ebe;
    int          nwait;
    ea = base + off;
    model(we, f3, ea, wdata, rdata, rdel, eerr, edata, ebe, emwd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    chk({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_base  = $urandom;
    bus.req_wdata = $urandom;
    if (eerr == 2'b00 || eerr == 2'b11) begin
      for (int i = 0; i <= gdel; i++) begin
        bus.mem_gnt = (i == gdel);
        chk({tag, "/mem_req"},  32'(bus.mem_req), 32'd1);
        chk({tag, "/mem_addr"}, bus.mem_addr, {ea[31:2], 2'b00});
        chk({tag, "/mem_be"},   32'(bus.mem_be), 32'(ebe));
        chk({tag, "/mem_we"},   32'(bus.mem_we), 32'(we));
        if (we) chk({tag, "/mem_wdata"}, bus.mem_wdata, emwd);
        chk({tag, "/early_resp"}, 32'(bus.resp_valid), 32'd0);
        tick();
      end
      bus.mem_gnt = 1'b0;
      if (!we) begin
        nwait = (rdel >= TO) ? TO : rdel + 1;
        for (int i = 0; i < nwait; i++) begin
          bus.mem_rvalid = (i == rdel);
          bus.mem_rdata  = (i == rdel) ? rdata : $urandom;
          chk({tag, "/wait_req"}, 32'(bus.mem_req), 32'd0);
          chk({tag, "/wait_be"},  32'(bus.mem_be), 32'd0);
          chk({tag, "/wait_resp"}, 32'(bus.resp_valid), 32'd0);
          tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
    end else begin
      chk({tag, "/no_mem_req"}, 32'(bus.mem_req), 32'd0);
    end
    for (int i = 0; i <= rdly; i++) begin
      chk({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, "/resp_err"},   32'(bus.resp_err), 32'(eerr));
      chk({tag, "/resp_data"},  bus.resp_data, edata);
      chk({tag, "/resp_rd"},    32'(bus.resp_rd), we ? 32'd0 : 32'(rd));
      chk({tag, "/resp_addr"},  bus.resp_addr, ea);
      chk({tag, "/busy"},       32'(bus.req_ready), 32'd0);
      bus.resp_ready = (i == rdly);
      tick();
    end
    bus.resp_ready = 1'b0;
    chk({tag, "/resp_done"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "/idle"},      32'(bus.req_ready), 32'd1);
    $display("txn %s we=%0d f3=%0d ea=0x%08h err=%0d data=0x%08h", tag, we, f3, ea, eerr, edata);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] rbase;
    bit          rwe;
    rst_n = 1'b0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_base = 0;
    bus.req_offset = 0; bus.req_wdata = 0; bus.req_rd = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.resp_ready = 0;
    tick(); tick();
    chk("rst/req_ready",  32'(bus.req_ready), 32'd1);
    chk("rst/mem_req",    32'(bus.mem_req), 32'd0);
    chk("rst/mem_be",     32'(bus.mem_be), 32'd0);
    chk("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst/resp_data",  bus.resp_data, 32'd0);
    rst_n = 1'b1;
    tick();

    txn("sw",       1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd3, 32'h0, 0, 0, 0);
    txn("lb",       0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd7, 32'h80112233, 0, 0, 0);
    txn("lbu",      0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd8, 32'h80112233, 0, 1, 0);
    txn("lh",       0, 3'b001, 32'h100, 32'h2, 32'h0, 5'd9, 32'h9ABC1234, 0, 0, 0);
    txn("sh",       1, 3'b001, 32'h100, 32'h2, 32'h00005678, 5'd1, 32'h0, 0, 0, 0);
    txn("lw_mis",   0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd4, 32'h0, 0, 0, 0);
    txn("ld_ill",   0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd5, 32'h0, 0, 0, 0);
    txn("gnt_stall",1, 3'b000, 32'h300, 32'h1, 32'h000000A5, 5'd0, 32'h0, 5, 0, 0);
    txn("timeout",  0, 3'b010, 32'h400, 32'h0, 32'h0, 5'd6, 32'h12345678, 0, 99, 0);
    txn("rv_expire",0, 3'b101, 32'h400, 32'h2, 32'h0, 5'd6, 32'hF00DCAFE, 0, TO - 1, 0);
    txn("backpress",0, 3'b010, 32'h500, 32'hFFFFFFFC, 32'h0, 5'd31, 32'hCAFEF00D, 1, 2, 3);

    // Reset while waiting for read data, then a stale rvalid.
    bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b010;
    bus.req_base = 32'h600; bus.req_offset = 0; bus.req_rd = 5'd2;
    tick();
    bus.req_valid = 0; bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_wait/mem_req",    32'(bus.mem_req), 32'd0);
    chk("rst_wait/req_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_wait/resp_valid", 32'(bus.resp_valid), 32'd0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h11111111;
    tick();
    bus.mem_rvalid = 0;
    chk("stale_rv/resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("stale_rv/req_ready",  32'(bus.req_ready), 32'd1);
    tick();
    chk("stale_rv/resp_valid2", 32'(bus.resp_valid), 32'd0);
    $display("txn rst_wait reset during WAIT, stale rvalid ignored");

    for (int n = 0; n < 60; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      rbase = $urandom;
      if ($urandom_range(0, 3) != 0)
        rf3 = rwe ? 3'($urandom_range(0, 2)) : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      txn($sformatf("rnd%0d", n), rwe, rf3, rbase, 32'($signed(12'($urandom))),
          $urandom, 5'($urandom), $urandom, $urandom_range(0, 3),
          $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
